bip_core_param: RTL and testbench
=================================

# bip_core_param

Parametrised accumulator-based BIP processor core, the next generation of the fixed-width `bip` top. It fetches one instruction per cycle from an external instruction memory addressed by `pc` and executes the BIP-I instruction set plus two control-flow extensions (JMP, BZ). Memory operand accesses use a req/ack data-memory handshake that can stall the core. It reports halt status and a run-cycle counter for benchmarking, and sits between the instruction ROM and the data RAM inside the `bip` top level.

## Interface
Parameters:
- `DATA_W`, 16: accumulator and data-memory word width (≥ ADDR_W).
- `ADDR_W`, 11: operand, PC and data-address width.
- `OPC_W`, 5: opcode width; instruction width is OPC_W+ADDR_W.
- `CNT_W`, 32: cycle-counter width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  out  ADDR_W  instruction-memory address (current PC).
- `imem_data`  in  OPC_W+ADDR_W  instruction at `pc`, combinational, same cycle; opcode in the MSBs, operand in the LSBs.
- `dmem_req`  out  1  data access request (combinational).
- `dmem_we`  out  1  1 = write (STO), 0 = read; valid while `dmem_req`=1.
- `dmem_addr`  out  ADDR_W  operand field of the current instruction.
- `dmem_wdata`  out  DATA_W  equals `acc`.
- `dmem_rdata`  in  DATA_W  read data, sampled when `dmem_ack`=1.
- `dmem_ack`  in  1  access complete this cycle; may be high in the same cycle as the request.
- `acc`  out  DATA_W  accumulator.
- `halted`  out  1  core is in HALT.
- `cycle_count`  out  CNT_W  number of RUN cycles since reset.

## Operation
- States: BOOT, RUN, HALT. Reset forces BOOT.
- BOOT → RUN on the first rising edge after `reset` deasserts. No execution and no request in BOOT.
- RUN: decode `imem_data` every cycle. Opcodes, with `op` = operand:
  - 00000 HLT: go to HALT; PC unchanged.
  - 00001 STO: mem[op] ← acc.
  - 00010 LD: acc ← mem[op].
  - 00011 LDI: acc ← sext(op).
  - 00100 ADD: acc ← acc + mem[op].
  - 00101 ADDI: acc ← acc + sext(op).
  - 00110 SUB: acc ← acc − mem[op].
  - 00111 SUBI: acc ← acc − sext(op).
  - 01000 JMP: pc ← op.
  - 01001 BZ: pc ← op if acc == 0, else pc+1.
  - All other opcodes: NOP, pc+1.
- `sext` sign-extends the ADDR_W operand to DATA_W.
- Arithmetic wraps modulo 2^DATA_W. No flags, no overflow trap.
- PC increments modulo 2^ADDR_W: 2^ADDR_W−1 wraps to 0.
- Memory ops (STO, LD, ADD, SUB): `dmem_req`=1 while in RUN with that opcode.
  - On an edge with `dmem_ack`=1: commit the result and set pc+1.
  - Otherwise: stall. pc and acc hold, and the request is held with stable addr, we and wdata.
- HALT is terminal until reset. `dmem_req`=0 and pc, acc and cycle_count are frozen.
- `cycle_count` increments on every RUN edge, including stall cycles and the HLT cycle. It saturates at 2^CNT_W−1.

## Timing
- Reset values: pc=0, acc=0, halted=0, cycle_count=0, state=BOOT.
- `dmem_req`=0, `dmem_we`=0 during reset and BOOT.
- Non-memory instruction: 1 cycle, with the result visible after the edge.
- Memory instruction: 1+N cycles, where N is the number of ack-low cycles.
- `halted` rises on the edge that executes HLT.
- `dmem_req`, `dmem_we` and `dmem_addr` are combinational from state and `imem_data`. `dmem_ack` is ignored when `dmem_req`=0.
- Reset asserted mid-stall: state leaves the in-flight access immediately.
  - `dmem_req` drops asynchronously and the access is not committed.
  - After release the core restarts at pc=0.
- BZ evaluates `acc` before any update in the same cycle.

## Test plan
- Reset release: program LDI 5; ADDI −3; HLT.
  - halted=1 after 1 BOOT + 3 RUN edges.
  - acc=0x0002, pc=2, cycle_count=3.
- Memory with ack tied 1: program LDI 7; STO 10; LDI 0; ADD 10; SUB 10; HLT.
  - Write of 0x0007 to addr 10.
  - Final acc=0x0000, cycle_count=6.
- Stall handling: LD 4 with ack low for 3 cycles, then high, rdata=0x1234.
  - Request held 4 cycles with addr=4 and we=0.
  - pc stays constant during the stall, then acc=0x1234 and pc+1.
- Branch and wrap: LDI 0; BZ 0x7FF; at 0x7FF a NOP.
  - pc goes to 0x7FF, then wraps to 0x000.
  - Second pass with acc≠0: BZ falls through.
- Arithmetic wrap: LDI −1 (0xFFFF); ADDI 1.
  - acc=0x0000.
  - SUBI 1 from 0 gives 0xFFFF.
- Reset mid-stall: assert reset during an ack-low LD.
  - dmem_req=0 immediately and acc=0.
  - After release, the core reruns from pc=0 with cycle_count restarted at 0.

Source files
------------

// File: rtl/bip_core_param.sv
// Parametrised BIP-I accumulator core with JMP/BZ extensions.
// Fetches from a combinational instruction ROM; memory operands use a req/ack handshake that can stall.
module bip_core_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned OPC_W  = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDR_W-1:0]         pc,
    input  logic [OPC_W+ADDR_W-1:0]   imem_data,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_W-1:0]         dmem_addr,
    output logic [DATA_W-1:0]         dmem_wdata,
    input  logic [DATA_W-1:0]         dmem_rdata,
    input  logic                      dmem_ack,
    output logic [DATA_W-1:0]         acc,
    output logic                      halted,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int unsigned INSTR_W = OPC_W + ADDR_W;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_BZ   = OPC_W'(9);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halted_q, halted_d;

    logic [OPC_W-1:0]    opc;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W-1:0]   imm_sext;
    logic [ADDR_W-1:0]   pc_inc;
    logic                is_mem_op;

    assign opc      = imem_data[INSTR_W-1 -: OPC_W];
    assign operand  = imem_data[ADDR_W-1:0];
    assign imm_sext = DATA_W'($signed(operand));
    assign pc_inc   = pc_q + ADDR_W'(1);

    assign is_mem_op = (opc == OP_STO) || (opc == OP_LD) ||
                       (opc == OP_ADD) || (opc == OP_SUB);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (opc == OP_HLT) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    // Execute / output logic; a memory op without ack holds every register except the cycle counter
    always_comb begin
        pc_d      = pc_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        if (state_q == ST_RUN) begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            dmem_req = is_mem_op;
            dmem_we  = (opc == OP_STO);
            unique case (opc)
                OP_HLT:  halted_d = 1'b1;
                OP_STO:  if (dmem_ack) pc_d = pc_inc;
                OP_LD:   if (dmem_ack) begin acc_d = dmem_rdata;         pc_d = pc_inc; end
                OP_ADD:  if (dmem_ack) begin acc_d = acc_q + dmem_rdata; pc_d = pc_inc; end
                OP_SUB:  if (dmem_ack) begin acc_d = acc_q - dmem_rdata; pc_d = pc_inc; end
                OP_LDI:  begin acc_d = imm_sext;         pc_d = pc_inc; end
                OP_ADDI: begin acc_d = acc_q + imm_sext; pc_d = pc_inc; end
                OP_SUBI: begin acc_d = acc_q - imm_sext; pc_d = pc_inc; end
                OP_JMP:  pc_d = operand;
                OP_BZ:   pc_d = (acc_q == '0) ? operand : pc_inc;
                default: pc_d = pc_inc;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign acc         = acc_q;
    assign cycle_count = cnt_q;
    assign halted      = halted_q;
    assign dmem_addr   = operand;
    assign dmem_wdata  = acc_q;

endmodule

// File: tb/tb_bip_core_param.sv
// Directed self-checking bench for bip_core_param: small programs in a bench-side ROM,
// scripted data-memory ack, hand-computed expectations.
module tb_bip_core_param;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned CNT_W  = 32;

    logic                    clk;
    logic                    reset;
    logic [ADDR_W-1:0]       pc;
    logic [OPC_W+ADDR_W-1:0] imem_data;
    logic                    dmem_req;
    logic                    dmem_we;
    logic [ADDR_W-1:0]       dmem_addr;
    logic [DATA_W-1:0]       dmem_wdata;
    logic [DATA_W-1:0]       dmem_rdata;
    logic                    dmem_ack;
    logic [DATA_W-1:0]       acc;
    logic                    halted;
    logic [CNT_W-1:0]        cycle_count;

    logic [15:0] imem [0:2047];
    logic [15:0] wmem [0:2047];
    int          wr_cnt;
    logic [10:0] last_waddr;
    logic [15:0] last_wdata;

    int errors;
    int checks;

    bip_core_param #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .acc(acc), .halted(halted), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data  = imem[pc];
    // Address 4 is a fixed read-only word; everything else reads back what was stored
    assign dmem_rdata = (dmem_addr == 11'd4) ? 16'h1234 : wmem[dmem_addr];

    initial begin
        wr_cnt     = 0;
        last_waddr = '0;
        last_wdata = '0;
    end

    always @(posedge clk) begin
        if (reset && dmem_req && dmem_we && dmem_ack) begin
            wmem[dmem_addr] <= dmem_wdata;
            last_waddr      <= dmem_addr;
            last_wdata      <= dmem_wdata;
            wr_cnt          <= wr_cnt + 1;
        end
    end

    function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
        return {o, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
    endtask

    task automatic run_until_halt(input int max_edges, output int edges);
        edges = 0;
        while (!halted && edges < max_edges) begin
            step();
            edges++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    int edges;
    int wr_base;

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        dmem_ack = 1'b1;

        // Reset release: LDI 5; ADDI -3; HLT
        clear_imem();
        imem[0] = ins(5'd3, 11'd5);
        imem[1] = ins(5'd5, 11'h7FD);
        imem[2] = ins(5'd0, 11'd0);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cnt", cycle_count, 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        reset = 1'b1;
        run_until_halt(20, edges);
        check("t1_edges", 32'(edges), 32'd4);
        check("t1_acc", 32'(acc), 32'h0002);
        check("t1_pc", 32'(pc), 32'd2);
        check("t1_cnt", cycle_count, 32'd3);
        step();
        check("t1_frozen_cnt", cycle_count, 32'd3);
        check("t1_frozen_req", 32'(dmem_req), 32'd0);

        // Memory with ack tied high
        reset = 1'b0;
        clear_imem();
        imem[0] = ins(5'd3, 11'd7);
        imem[1] = ins(5'd1, 11'd10);
        imem[2] = ins(5'd3, 11'd0);
        imem[3] = ins(5'd4, 11'd10);
        imem[4] = ins(5'd6, 11'd10);
        imem[5] = ins(5'd0, 11'd0);
        @(negedge clk);
        check("t2_rst_acc", 32'(acc), 32'd0);
        wr_base = wr_cnt;
        reset = 1'b1;
        run_until_halt(30, edges);
        check("t2_wr_count", 32'(wr_cnt - wr_base), 32'd1);
        check("t2_waddr", 32'(last_waddr), 32'd10);
        check("t2_wdata", 32'(last_wdata), 32'h0007);
        check("t2_acc", 32'(acc), 32'h0000);
        check("t2_cnt", cycle_count, 32'd6);
        check("t2_pc", 32'(pc), 32'd5);

        // Stall: LD 4 with ack low for 3 cycles
        reset = 1'b0;
        dmem_ack = 1'b0;
        clear_imem();
        imem[0] = ins(5'd2, 11'd4);
        imem[1] = ins(5'd0, 11'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t3_boot_req", 32'(dmem_req), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_req", 32'(dmem_req), 32'd1);
            check("t3_stall_addr", 32'(dmem_addr), 32'd4);
            check("t3_stall_we", 32'(dmem_we), 32'd0);
            check("t3_stall_pc", 32'(pc), 32'd0);
            check("t3_stall_acc", 32'(acc), 32'd0);
            step();
        end
        check("t3_req4", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1;
        step();
        check("t3_acc", 32'(acc), 32'h1234);
        check("t3_pc", 32'(pc), 32'd1);
        run_until_halt(10, edges);
        check("t3_cnt", cycle_count, 32'd5);

        // Branch and PC wrap
        reset = 1'b0;
        clear_imem();
        imem[0]     = ins(5'd3, 11'd0);
        imem[1]     = ins(5'd9, 11'h7FF);
        imem[2]     = ins(5'd0, 11'd0);
        imem[11'h7FF] = ins(5'd15, 11'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        check("t4_ldi_pc", 32'(pc), 32'd1);
        step();
        check("t4_bz_taken", 32'(pc), 32'h7FF);
        step();
        check("t4_wrap", 32'(pc), 32'h000);
        imem[0] = ins(5'd3, 11'd3);
        step();
        check("t4_acc3", 32'(acc), 32'd3);
        step();
        check("t4_bz_fall", 32'(pc), 32'd2);
        step();
        check("t4_halted", 32'(halted), 32'd1);

        // Arithmetic wrap
        reset = 1'b0;
        clear_imem();
        imem[0] = ins(5'd3, 11'h7FF);
        imem[1] = ins(5'd5, 11'd1);
        imem[2] = ins(5'd7, 11'd1);
        imem[3] = ins(5'd0, 11'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        check("t5_ldi_m1", 32'(acc), 32'hFFFF);
        step();
        check("t5_addi_wrap", 32'(acc), 32'h0000);
        step();
        check("t5_subi_wrap", 32'(acc), 32'hFFFF);

        // Reset asserted in the middle of a stalled LD
        reset = 1'b0;
        dmem_ack = 1'b0;
        clear_imem();
        imem[0] = ins(5'd3, 11'd9);
        imem[1] = ins(5'd2, 11'd4);
        imem[2] = ins(5'd0, 11'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        check("t6_acc9", 32'(acc), 32'd9);
        step();
        check("t6_stall_req", 32'(dmem_req), 32'd1);
        check("t6_stall_pc", 32'(pc), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_async_req", 32'(dmem_req), 32'd0);
        check("t6_async_acc", 32'(acc), 32'd0);
        check("t6_async_pc", 32'(pc), 32'd0);
        check("t6_async_cnt", cycle_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dmem_ack = 1'b1;
        step();
        check("t6_boot_pc", 32'(pc), 32'd0);
        check("t6_boot_cnt", cycle_count, 32'd0);
        step();
        check("t6_rerun_acc", 32'(acc), 32'd9);
        check("t6_rerun_cnt", cycle_count, 32'd1);
        step();
        check("t6_ld_acc", 32'(acc), 32'h1234);
        check("t6_ld_pc", 32'(pc), 32'd2);
        run_until_halt(10, edges);
        check("t6_cnt", cycle_count, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
